mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported instruction/data memory between two requesters.
- Port 0 is the CPU memory interface (mem_cmd/mem_addr/write_data/read_data). Port 1 is a secondary master, such as a program loader or a DMA engine.
- Sequences each transaction through arbitrate, issue and respond phases, and stalls the requester that is not being served.
- Sits between the cpu and the RAM in the top level.

Parameters:
- AW, 9, memory address width.
- DW, 16, memory data width.
- RD_LAT, 1, memory read latency in cycles; legal range 1..4.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- m0_cmd  input  2  port 0 command: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 ignored (treated as NONE).
- m0_addr  input  AW  port 0 address.
- m0_wdata  input  DW  port 0 write data.
- m0_rdata  output  DW  port 0 read data, registered.
- m0_done  output  1  one-cycle completion pulse for port 0.
- m0_stall  output  1  port 0 request pending and not completing this cycle.
- m1_cmd, m1_addr, m1_wdata, m1_rdata, m1_done, m1_stall: same as port 0, for port 1.
- mem_cmd  output  2  command to RAM.
- mem_addr  output  AW  address to RAM.
- mem_wdata  output  DW  write data to RAM.
- mem_rdata  input  DW  read data from RAM.
- grant  output  1  index of the port owning the current or last transaction.

Behaviour:
- Reset values (applied on the clock edge with reset high):
  - state=IDLE; mem_cmd=NONE; mem_addr=0; mem_wdata=0.
  - m0_rdata=m1_rdata=0; m0_done=m1_done=0.
  - last-served pointer=1, so port 0 wins the first tie; grant=0.
- Request protocol:
  - A requester drives cmd!=NONE and holds cmd/addr/wdata until it sees its done pulse.
  - Arbiter latches cmd/addr/wdata at grant. Later changes to those inputs are ignored until done.
  - Dropping cmd mid-transaction does not abort it; done still pulses.
- FSM IDLE: if no valid request, stay in IDLE.
  - If one port requests, grant it.
  - If both request, grant the port not equal to last-served (round-robin).
  - On grant: latch request, update grant, go to ISSUE, and load the latency counter (RD_LAT for READ, 1 for WRITE).
- FSM ISSUE: mem_cmd/mem_addr/mem_wdata are registered copies of the latched request.
  - Hold them while the counter decrements.
  - When the counter reaches 1, go to RESP.
- FSM RESP: mem_cmd=NONE.
  - done of the granted port =1 for exactly this cycle.
  - For a READ, capture mem_rdata into the granted port's rdata on entry. The value holds until that port's next READ completes.
  - The other port's rdata is untouched.
  - Update last-served = grant, then go to IDLE.
- Latency from request visible in IDLE to done:
  - READ: RD_LAT+1 cycles (RD_LAT=1: request T0, mem_cmd T1, done T2).
  - WRITE: 2 cycles.
  - Minimum issue spacing is 3 cycles per transaction at RD_LAT=1.
- Stall:
  - mX_stall = (mX_cmd is READ or WRITE) && !mX_done. Combinational from registered done.
  - A non-granted requester stays stalled until its own transaction completes.
- Fairness: under continuous requests from both ports, grants strictly alternate. No port waits more than one foreign transaction.
- Reset mid-transaction: the transaction is abandoned.
  - No done pulse is issued.
  - mem_cmd=NONE on the cycle after the reset edge.
  - Any RAM write already issued is not undone.
- Width rule: address and data pass through unmodified; no arithmetic on data.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRI_EN.
- Defined: port 0 (CPU) always wins simultaneous requests in IDLE. The last-served pointer is unused, and port 1 can starve.
- Undefined: round-robin as described above.
- In both cases a granted transaction always runs to completion uninterrupted.

Test Plan:
- Port 0 READ addr 9'h005, RAM[5]=16'hABCD, RD_LAT=1 -> mem_cmd=01/addr=005 in T1; m0_done=1 in T2; m0_rdata=16'hABCD from T3; m0_stall high T0–T1.
- Both ports request at T0 after reset (m0 WRITE addr 9'h010 data 16'h1234, m1 READ addr 9'h010) -> port 0 served first (grant=0); then port 1 reads 16'h1234; m1_stall high until m1_done.
- Both ports continuously issue 4 READs each -> grant sequence 0,1,0,1,0,1,0,1; no two consecutive dones on the same port.
- Reset asserted during ISSUE of a port 1 READ -> no m1_done; mem_cmd=00 after the edge; m1_rdata=0; next request is served normally.
- RD_LAT=3, port 1 READ addr 9'h1FF (top address) -> mem_cmd held 3 cycles T1–T3; m1_done at T4; correct data returned.
- With MEM_ARB_FIXED_PRI_EN, both ports requesting continuously -> port 0 granted every time; m1_done never pulses while m0 requests.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported RAM: port 0 is the CPU, port 1 a loader/DMA master.
// Round-robin on simultaneous requests by default; define MEM_ARB_FIXED_PRI_EN to give port 0 fixed priority.
module mem_port_arbiter #(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_done,
  output logic          m0_stall,
  input  logic [1:0]    m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_done,
  output logic          m1_stall,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [2:0] RD_CNT    = 3'(RD_LAT);
  localparam logic [2:0] WR_CNT    = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          is_read_q, is_read_d;
  logic [1:0]    mem_cmd_q, mem_cmd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          m0_done_q, m0_done_d;
  logic          m1_done_q, m1_done_d;

  logic          m0_valid;
  logic          m1_valid;
  logic          sel_port;
  logic [1:0]    sel_cmd;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // 2'b11 is treated exactly like NONE
  assign m0_valid = (m0_cmd == CMD_READ) || (m0_cmd == CMD_WRITE);
  assign m1_valid = (m1_cmd == CMD_READ) || (m1_cmd == CMD_WRITE);

`ifdef MEM_ARB_FIXED_PRI_EN
  // Arbitration choice: CPU always wins a tie.
  always_comb begin
    if (m0_valid) begin
      sel_port = 1'b0;
    end else begin
      sel_port = 1'b1;
    end
  end
`else
  // Arbitration choice: on a tie, serve the port that was not served last.
  always_comb begin
    if (m0_valid && m1_valid) begin
      sel_port = ~last_q;
    end else if (m0_valid) begin
      sel_port = 1'b0;
    end else begin
      sel_port = 1'b1;
    end
  end
`endif

  // Request mux for the selected port.
  always_comb begin
    if (sel_port) begin
      sel_cmd   = m1_cmd;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end else begin
      sel_cmd   = m0_cmd;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
  end

  // Next-state and datapath updates for the IDLE -> ISSUE -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    last_d      = last_q;
    is_read_d   = is_read_q;
    mem_cmd_d   = mem_cmd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_done_d   = 1'b0;
    m1_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_cmd_d = CMD_NONE;
        if (m0_valid || m1_valid) begin
          // mem_* registers double as the latched copy of the request
          grant_d     = sel_port;
          is_read_d   = (sel_cmd == CMD_READ);
          mem_cmd_d   = sel_cmd;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          cnt_d       = (sel_cmd == CMD_READ) ? RD_CNT : WR_CNT;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (cnt_q <= 3'd1) begin
          mem_cmd_d = CMD_NONE;
          state_d   = ST_RESP;
          if (grant_q) begin
            m1_done_d = 1'b1;
          end else begin
            m0_done_d = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q - 3'd1;
          state_d = ST_ISSUE;
        end
      end

      ST_RESP: begin
        mem_cmd_d = CMD_NONE;
        last_d    = grant_q;
        state_d   = ST_IDLE;
        if (is_read_q) begin
          if (grant_q) begin
            m1_rdata_d = mem_rdata;
          end else begin
            m0_rdata_d = mem_rdata;
          end
        end else begin
          m0_rdata_d = m0_rdata_q;
        end
      end

      default: begin
        mem_cmd_d = CMD_NONE;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      is_read_q   <= 1'b0;
      mem_cmd_q   <= CMD_NONE;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      m0_rdata_q  <= {DW{1'b0}};
      m1_rdata_q  <= {DW{1'b0}};
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      is_read_q   <= is_read_d;
      mem_cmd_q   <= mem_cmd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_done_q   <= m0_done_d;
      m1_done_q   <= m1_done_d;
    end
  end

  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_done   = m0_done_q;
  assign m1_done   = m1_done_q;
  assign grant     = grant_q;

  // Stall drops in the done cycle even if the requester still holds its command
  assign m0_stall  = m0_valid && !m0_done_q;
  assign m1_stall  = m1_valid && !m1_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, hand-written corner sequences,
// and a randomized run against a transaction-timeline reference model (RD_LAT=1 and RD_LAT=3 instances).
module tb_mem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] m0_cmd, m1_cmd, mem_cmd;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic m0_done, m1_done, m0_stall, m1_stall, grant;

  logic [1:0] b_m0_cmd, b_m1_cmd, b_mem_cmd;
  logic [AW-1:0] b_m0_addr, b_m1_addr, b_mem_addr;
  logic [DW-1:0] b_m0_wdata, b_m1_wdata, b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
  logic b_m0_done, b_m1_done, b_m0_stall, b_m1_stall, b_grant;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m0_done(m0_done), .m0_stall(m0_stall),
    .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .m1_done(m1_done), .m1_stall(m1_stall),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant(grant)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .m0_cmd(b_m0_cmd), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_rdata(b_m0_rdata),
    .m0_done(b_m0_done), .m0_stall(b_m0_stall),
    .m1_cmd(b_m1_cmd), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_rdata(b_m1_rdata),
    .m1_done(b_m1_done), .m1_stall(b_m1_stall),
    .mem_cmd(b_mem_cmd), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .grant(b_grant)
  );

  function automatic logic [15:0] init_val(input logic [8:0] a);
    if (a == 9'h005) return 16'hABCD;
    return {7'd0, a} ^ 16'h5A5A;
  endfunction

  // RAM models: contents preloaded on the first clock, read latency 1 and 3
  logic [DW-1:0] ram_a [0:511];
  logic [DW-1:0] ram_b [0:511];
  logic ram_a_init = 1'b0;
  logic ram_b_init = 1'b0;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b [0:2];

  always @(posedge clk) begin
    if (!ram_a_init) begin
      for (int i = 0; i < 512; i++) ram_a[i] <= init_val(9'(i));
      ram_a_init <= 1'b1;
    end else if (mem_cmd == 2'b10) begin
      ram_a[mem_addr] <= mem_wdata;
    end
    rd_a <= ram_a[mem_addr];
  end
  assign mem_rdata = rd_a;

  always @(posedge clk) begin
    if (!ram_b_init) begin
      for (int i = 0; i < 512; i++) ram_b[i] <= init_val(9'(i));
      ram_b_init <= 1'b1;
    end else if (b_mem_cmd == 2'b10) begin
      ram_b[b_mem_addr] <= b_mem_wdata;
    end
    rd_b[0] <= ram_b[b_mem_addr];
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign b_mem_rdata = rd_b[2];

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit valid(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  function automatic logic get_done(input bit p);
    return p ? m1_done : m0_done;
  endfunction

  function automatic logic get_stall(input bit p);
    return p ? m1_stall : m0_stall;
  endfunction

  task automatic drive(input bit p, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    if (p) begin
      m1_cmd = c; m1_addr = a; m1_wdata = d;
    end else begin
      m0_cmd = c; m0_addr = a; m0_wdata = d;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    drive(1'b0, 2'b00, 9'd0, 16'd0);
    drive(1'b1, 2'b00, 9'd0, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    bit          port;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    int          exp_lat;
    logic [15:0] exp_r0;
    logic [15:0] exp_r1;
  } vec_t;

  vec_t vecs [0:6];

  // One transaction from IDLE: checks issue cycle, stall, latency and both rdata values afterwards
  task automatic run_single(input vec_t v);
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    drive(v.port, v.cmd, v.addr, v.wdata);
    #1 chk("stall_t0", get_stall(v.port), v.exp_lat != 0);
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("issue_cmd", mem_cmd, (v.exp_lat != 0) ? v.cmd : 2'b00);
        if (v.exp_lat != 0) begin
          chk("issue_addr", mem_addr, v.addr);
          chk("issue_grant", grant, v.port);
          if (v.cmd == 2'b10) chk("issue_wdata", mem_wdata, v.wdata);
        end
      end
      if (get_done(v.port)) begin
        seen = 1'b1;
        lat = k;
        chk("stall_at_done", get_stall(v.port), 1'b0);
      end else begin
        chk("stall_wait", get_stall(v.port), v.exp_lat != 0);
      end
    end
    drive(v.port, 2'b00, 9'd0, 16'd0);
    chk("latency", lat, v.exp_lat);
    @(posedge clk); #1;
    chk("done_one_cycle", get_done(v.port), 1'b0);
    chk("rdata0_after", m0_rdata, v.exp_r0);
    chk("rdata1_after", m1_rdata, v.exp_r1);
  endtask

  // reference-model state for the random run
  logic [15:0] mm [0:15];
  bit          m_busy, m_port, m_read, m_last, m_grant;
  int          m_tg, m_lat;
  logic [8:0]  m_addr;
  logic [15:0] m_data, m_val;
  logic [15:0] m_rd [0:1];
  bit          pend [0:1];
  logic [1:0]  h_cmd [0:1];
  logic [8:0]  h_addr [0:1];
  logic [15:0] h_wd [0:1];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, nd, cnt0, cnt1;
    bit e_d0, e_d1, v0, v1, ps;
    logic [1:0] e_cmd;
    int order [0:7];
    bit chk_next [0:1];
    logic [15:0] chk_val [0:1];

    vecs[0] = '{1'b0, 2'b01, 9'h005, 16'h0000, 2, 16'hABCD, 16'h0000};
    vecs[1] = '{1'b1, 2'b10, 9'h1FF, 16'hBEEF, 2, 16'hABCD, 16'h0000};
    vecs[2] = '{1'b1, 2'b01, 9'h1FF, 16'h0000, 2, 16'hABCD, 16'hBEEF};
    vecs[3] = '{1'b0, 2'b10, 9'h000, 16'h0000, 2, 16'hABCD, 16'hBEEF};
    vecs[4] = '{1'b0, 2'b01, 9'h000, 16'h0000, 2, 16'h0000, 16'hBEEF};
    vecs[5] = '{1'b1, 2'b01, 9'h005, 16'h0000, 2, 16'h0000, 16'hABCD};
    vecs[6] = '{1'b0, 2'b11, 9'h005, 16'h1111, 0, 16'h0000, 16'hABCD};

    b_m0_cmd = 2'b00; b_m0_addr = 9'd0; b_m0_wdata = 16'd0;
    b_m1_cmd = 2'b00; b_m1_addr = 9'd0; b_m1_wdata = 16'd0;
    reset_dut();

    chk("rst_mem_cmd", mem_cmd, 2'b00);
    chk("rst_mem_addr", mem_addr, 9'h000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_rdata0", m0_rdata, 16'h0000);
    chk("rst_rdata1", m1_rdata, 16'h0000);
    chk("rst_done0", m0_done, 1'b0);
    chk("rst_done1", m1_done, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_stall0", m0_stall, 1'b0);

    // RD_LAT=3 instance: top-address read, then a write
    b_m1_cmd = 2'b01; b_m1_addr = 9'h1FF;
    #1 chk("l3_stall_t0", b_m1_stall, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k <= 3) begin
        chk("l3_mem_cmd", b_mem_cmd, 2'b01);
        chk("l3_mem_addr", b_mem_addr, 9'h1FF);
        chk("l3_no_done", b_m1_done, 1'b0);
      end else begin
        chk("l3_resp_cmd", b_mem_cmd, 2'b00);
        chk("l3_done", b_m1_done, 1'b1);
        b_m1_cmd = 2'b00;
      end
    end
    @(posedge clk); #1;
    chk("l3_rdata", b_m1_rdata, init_val(9'h1FF));
    chk("l3_grant", b_grant, 1'b1);
    chk("l3_done_clear", b_m1_done, 1'b0);
    b_m0_cmd = 2'b10; b_m0_addr = 9'h0A0; b_m0_wdata = 16'h7E57;
    @(posedge clk); #1;
    chk("l3_wr_cmd", b_mem_cmd, 2'b10);
    chk("l3_wr_wdata", b_mem_wdata, 16'h7E57);
    @(posedge clk); #1;
    chk("l3_wr_done", b_m0_done, 1'b1);
    b_m0_cmd = 2'b00;
    @(posedge clk); #1;
    chk("l3_wr_rdata1_kept", b_m1_rdata, init_val(9'h1FF));

    // directed single-transaction table
    for (int i = 0; i < 7; i++) run_single(vecs[i]);

    // simultaneous requests after reset: port 0 write, then port 1 reads it back
    reset_dut();
    drive(1'b0, 2'b10, 9'h010, 16'h1234);
    drive(1'b1, 2'b01, 9'h010, 16'h0000);
    d0 = -1; d1 = -1;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin
        chk("both_grant0", grant, 1'b0);
        chk("both_cmd0", mem_cmd, 2'b10);
        chk("both_wdata0", mem_wdata, 16'h1234);
      end
      if (k == 4) begin
        chk("both_grant1", grant, 1'b1);
        chk("both_cmd1", mem_cmd, 2'b01);
        chk("both_addr1", mem_addr, 9'h010);
      end
      if (m0_done && d0 < 0) begin d0 = k; m0_cmd = 2'b00; end
      if (m1_done && d1 < 0) begin d1 = k; m1_cmd = 2'b00; end
      #1 chk("both_m1_stall", m1_stall, d1 < 0);
      @(posedge clk); #1;
    end
    chk("both_done0_cycle", d0, 2);
    chk("both_done1_cycle", d1, 5);
    chk("both_m1_rdata", m1_rdata, 16'h1234);

    // continuous requests from both ports, 4 reads each
    reset_dut();
    cnt0 = 0; cnt1 = 0; nd = 0;
    chk_next[0] = 1'b0; chk_next[1] = 1'b0;
    drive(1'b0, 2'b01, 9'h120, 16'd0);
    drive(1'b1, 2'b01, 9'h130, 16'd0);
    for (int k = 0; k < 40; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (chk_next[p]) begin
          chk("fair_rdata", p ? m1_rdata : m0_rdata, chk_val[p]);
          chk_next[p] = 1'b0;
        end
      end
      chk("fair_not_both", m0_done && m1_done, 1'b0);
      if (m0_done && nd < 8) begin
        order[nd] = 0; nd++;
        chk_next[0] = 1'b1; chk_val[0] = init_val(m0_addr);
        cnt0++;
        drive(1'b0, (cnt0 < 4) ? 2'b01 : 2'b00, 9'h120 + 9'(cnt0), 16'd0);
      end
      if (m1_done && nd < 8) begin
        order[nd] = 1; nd++;
        chk_next[1] = 1'b1; chk_val[1] = init_val(m1_addr);
        cnt1++;
        drive(1'b1, (cnt1 < 4) ? 2'b01 : 2'b00, 9'h130 + 9'(cnt1), 16'd0);
      end
      @(posedge clk); #1;
    end
    chk("fair_count", nd, 8);
    for (int i = 0; i < nd; i++) begin
`ifdef MEM_ARB_FIXED_PRI_EN
      chk("fair_order", order[i], (i < 4) ? 0 : 1);
`else
      chk("fair_order", order[i], i % 2);
`endif
    end

    // reset while a port 1 read is being issued
    drive(1'b1, 2'b01, 9'h1FF, 16'd0);
    @(posedge clk); #1;
    chk("rstmid_issue", mem_cmd, 2'b01);
    reset = 1'b1;
    m1_cmd = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_cmd", mem_cmd, 2'b00);
    chk("rstmid_done", m1_done, 1'b0);
    chk("rstmid_rdata", m1_rdata, 16'h0000);
    chk("rstmid_grant", grant, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rstmid_no_done", m1_done, 1'b0);
    end
    run_single('{1'b1, 2'b01, 9'h1FF, 16'h0000, 2, 16'h0000, 16'hBEEF});

    // randomized run against the timeline model
    reset_dut();
    for (int i = 0; i < 16; i++) mm[i] = init_val(9'h100 + 9'(i));
    m_busy = 1'b0; m_last = 1'b1; m_grant = 1'b0; m_tg = 0; m_lat = 0;
    m_rd[0] = 16'd0; m_rd[1] = 16'd0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (m_busy && c == m_tg + m_lat + 2) begin
        if (m_read) m_rd[m_port] = m_val;
        m_busy = 1'b0;
      end
      e_d0 = m_busy && !m_port && (c == m_tg + m_lat + 1);
      e_d1 = m_busy && m_port && (c == m_tg + m_lat + 1);
      e_cmd = (m_busy && c >= m_tg + 1 && c <= m_tg + m_lat) ? (m_read ? 2'b01 : 2'b10) : 2'b00;
      chk("rnd_done0", m0_done, e_d0);
      chk("rnd_done1", m1_done, e_d1);
      chk("rnd_mem_cmd", mem_cmd, e_cmd);
      chk("rnd_grant", grant, m_grant);
      chk("rnd_rdata0", m0_rdata, m_rd[0]);
      chk("rnd_rdata1", m1_rdata, m_rd[1]);
      if (e_cmd != 2'b00) chk("rnd_mem_addr", mem_addr, m_addr);
      if (e_cmd == 2'b10) chk("rnd_mem_wdata", mem_wdata, m_data);

      for (int p = 0; p < 2; p++) begin
        if (pend[p] && get_done(1'(p))) pend[p] = 1'b0;
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          h_cmd[p] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
          h_addr[p] = 9'h100 + 9'($urandom_range(0, 15));
          h_wd[p] = 16'($urandom);
        end
        if (pend[p]) begin
          if (m_busy && m_port == 1'(p) && $urandom_range(0, 3) == 0)
            drive(1'(p), 2'($urandom), 9'($urandom), 16'($urandom));
          else
            drive(1'(p), h_cmd[p], h_addr[p], h_wd[p]);
        end else begin
          drive(1'(p), ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00, 9'($urandom), 16'($urandom));
        end
      end
      #1;
      chk("rnd_stall0", m0_stall, valid(m0_cmd) && !e_d0);
      chk("rnd_stall1", m1_stall, valid(m1_cmd) && !e_d1);

      v0 = valid(m0_cmd);
      v1 = valid(m1_cmd);
      if (!m_busy && (v0 || v1)) begin
`ifdef MEM_ARB_FIXED_PRI_EN
        ps = v0 ? 1'b0 : 1'b1;
`else
        ps = (v0 && v1) ? ~m_last : (v0 ? 1'b0 : 1'b1);
`endif
        m_busy = 1'b1;
        m_port = ps;
        m_tg = c;
        m_read = ((ps ? m1_cmd : m0_cmd) == 2'b01);
        m_addr = ps ? m1_addr : m0_addr;
        m_data = ps ? m1_wdata : m0_wdata;
        m_lat = 1;
        m_grant = ps;
        m_last = ps;
        if (m_read) m_val = mm[m_addr[3:0]];
        else mm[m_addr[3:0]] = m_data;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
